// File: rtl/muldiv_unit_pkg.sv
// Shared defines for the mul/div unit: op and state encodings, stall constants, ZeroWord.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [63:0] ZeroWord = 64'h0;

endpackage

// File: rtl/muldiv_core_div.sv
// Restoring radix-2 divider datapath on unsigned magnitudes; exposes the next-step
// quotient/remainder so the owner can commit on the final iteration edge.
module muldiv_core_div
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_nxt,
  output logic [XLEN-1:0] rem_nxt
);

  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;

  // Quotient register doubles as the dividend shifter.
  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvsr_q};

  always_comb begin
    if (!diff[XLEN]) begin
      rem_nxt = diff[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvsr_d = dvsr_q;
    if (load) begin
      quo_d  = dividend;
      rem_d  = ZeroWord[XLEN-1:0];
      dvsr_d = divisor;
    end else if (step) begin
      quo_d  = quo_nxt;
      rem_d  = rem_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvsr_q <= dvsr_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply-divide unit: FSM, sign handling, MTHI/MTLO and multiplier.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            annul,
  output logic            stallreq,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] a_q, a_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic            bzero_q, bzero_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            done_q, done_d;

  op_e             op_i;
  logic            sgn_op, s1, s2;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_load, div_step;
  logic [XLEN-1:0] div_quo, div_rem;

  assign op_i   = op_e'(op);
  assign sgn_op = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign s1     = sgn_op & src1[XLEN-1];
  assign s2     = sgn_op & src2[XLEN-1];
  assign mag1   = s1 ? -src1 : src1;
  assign mag2   = s2 ? -src2 : src2;

`ifndef MULDIV_FAST_MUL_EN
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;

  // Upper half accumulates, lower half shifts the multiplier out LSB first.
  assign mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                   {1'b0, (prod_q[0] ? mcand_q : ZeroWord[XLEN-1:0])};
  assign mul_nxt = {mul_sum, prod_q[XLEN-1:1]};
`else
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = (2*XLEN)'(mag1) * (2*XLEN)'(mag2);
`endif

  muldiv_core_div #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (mag1),
    .divisor  (mag2),
    .quo_nxt  (div_quo),
    .rem_nxt  (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    div_load  = 1'b0;
    div_step  = 1'b0;
`ifndef MULDIV_FAST_MUL_EN
    mcand_d   = mcand_q;
    prod_d    = prod_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start && !annul) begin
          if (!op[2]) begin
            a_d       = src1;
            neg_res_d = s1 ^ s2;
            neg_rem_d = s1;
            bzero_d   = (src2 == ZeroWord[XLEN-1:0]);
            cnt_d     = CNT_LAST;
          end
          case (op_i)
            OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
              {hi_d, lo_d} = (s1 ^ s2) ? -fast_prod : fast_prod;
              done_d       = 1'b1;
              state_d      = ST_DONE;
`else
              mcand_d = mag2;
              prod_d  = {ZeroWord[XLEN-1:0], mag1};
              state_d = ST_MUL;
`endif
            end
            OP_DIV, OP_DIVU: begin
              div_load = 1'b1;
              state_d  = ST_DIV;
            end
            OP_MTHI: hi_d = src1;
            OP_MTLO: lo_d = src1;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
`ifndef MULDIV_FAST_MUL_EN
        if (annul) begin
          state_d = ST_IDLE;
        end else begin
          prod_d = mul_nxt;
          if (cnt_q == '0) begin
            {hi_d, lo_d} = neg_res_q ? -mul_nxt : mul_nxt;
            done_d       = 1'b1;
            state_d      = ST_DONE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DIV: begin
        if (annul) begin
          state_d = ST_IDLE;
        end else begin
          div_step = 1'b1;
          if (cnt_q == '0) begin
            // Divide by zero bypasses sign fix-up: all-ones quotient, raw dividend.
            lo_d    = bzero_q ? {XLEN{1'b1}} : (neg_res_q ? -div_quo : div_quo);
            hi_d    = bzero_q ? a_q : (neg_rem_q ? -div_rem : div_rem);
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
`ifndef MULDIV_FAST_MUL_EN
      mcand_q   <= '0;
      prod_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
`ifndef MULDIV_FAST_MUL_EN
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
`endif
    end
  end

  always_comb begin
    stallreq = NoStop;
    if (!rst) begin
      case (state_q)
        ST_IDLE:        if (start && !op[2]) stallreq = Stop;
        ST_MUL, ST_DIV: stallreq = Stop;
        default:        stallreq = NoStop;
      endcase
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (default iterative build, XLEN=32).
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic        annul;
  logic        stallreq, done;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src1     (src1),
    .src2     (src2),
    .annul    (annul),
    .stallreq (stallreq),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Architectural result computed with plain 64-bit arithmetic.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] mh, output logic [31:0] ml);
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: p = 64'(sa * sb);
      3'd1: p = {32'b0, a} * {32'b0, b};
      3'd2: if (b == 32'd0) p = {a, 32'hFFFFFFFF};
            else p = {32'(sa % sb), 32'(sa / sb)};
      3'd3: if (b == 32'd0) p = {a, 32'hFFFFFFFF};
            else p = {a % b, a / b};
      default: p = 64'd0;
    endcase
    {mh, ml} = p;
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 4))
      0:       return 32'($signed($urandom_range(0, 40)) - 20);
      1:       return 32'd0;
      2:       return 32'h80000000;
      default: return $urandom();
    endcase
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit poke, input bit annul_done);
    logic [31:0] eh, el;
    int lat;
    bit stall_ok;
    model(o, a, b, eh, el);
    @(negedge clk);
    start = 1'b1; op = o; src1 = a; src2 = b;
    #1 chk("stall_accept", {63'd0, stallreq}, 64'd1);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    stall_ok = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      if (stallreq !== 1'b1) stall_ok = 1'b0;
      if (poke && lat == 5) begin
        start = 1'b1; op = 3'd4; src1 = 32'hDEADBEEF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("latency", 64'(lat), 64'd33);
    chk("stall_busy", {63'd0, stall_ok}, 64'd1);
    chk("stall_in_done", {63'd0, stallreq}, 64'd0);
    chk("hi", {32'd0, hi}, {32'd0, eh});
    chk("lo", {32'd0, lo}, {32'd0, el});
    if (annul_done) annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("hi_hold", {32'd0, hi}, {32'd0, eh});
    chk("lo_hold", {32'd0, lo}, {32'd0, el});
  endtask

  initial begin
    bit saw_done;
    rst = 1'b1; start = 1'b1; op = 3'd0; src1 = 32'd5; src2 = 32'd6; annul = 1'b0;
    #1;
    chk("rst_stall", {63'd0, stallreq}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    repeat (2) @(negedge clk);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    start = 1'b0;
    rst = 1'b0;

    do_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    do_op(3'd3, 32'h00001234, 32'd0, 1'b0, 1'b0);
    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    do_op(3'd2, 32'hFFFFFF00, 32'd0, 1'b0, 1'b0);
    do_op(3'd0, 32'h80000000, 32'h80000000, 1'b0, 1'b0);
    // start during an op is ignored; annul in DONE has no effect
    do_op(3'd3, 32'd1000, 32'd7, 1'b1, 1'b1);

    for (int i = 0; i < 24; i++) begin
      do_op(3'($urandom_range(0, 3)), rnd_word(), rnd_word(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // MTLO, then DIV annulled at N+10
    @(negedge clk);
    start = 1'b1; op = 3'd5; src1 = 32'hA5A5A5A5;
    #1 chk("mtlo_nostall", {63'd0, stallreq}, 64'd0);
    @(negedge clk);
    chk("mtlo_lo", {32'd0, lo}, 64'hA5A5A5A5);
    op = 3'd4; src1 = 32'h0000C0DE;
    @(negedge clk);
    chk("mthi_hi", {32'd0, hi}, 64'h0000C0DE);
    op = 3'd2; src1 = 32'd100; src2 = 32'd7;
    saw_done = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    #1 chk("annul_stall_low", {63'd0, stallreq}, 64'd0);
    start = 1'b1; op = 3'd4; src1 = 32'h0000005A;
    repeat (40) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    chk("annul_no_done", {63'd0, saw_done}, 64'd0);
    chk("annul_lo_kept", {32'd0, lo}, 64'hA5A5A5A5);
    chk("restart_mthi", {32'd0, hi}, 64'h0000005A);

    // annul together with start in IDLE wins
    start = 1'b1; annul = 1'b1; op = 3'd5; src1 = 32'h11111111;
    @(negedge clk);
    chk("annul_start_mtlo", {32'd0, lo}, 64'hA5A5A5A5);
    op = 3'd3; src1 = 32'd9; src2 = 32'd2;
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    #1 chk("annul_start_div", {63'd0, stallreq}, 64'd0);

    // reset in the middle of a MULT
    @(negedge clk);
    start = 1'b1; op = 3'd0; src1 = 32'h00012345; src2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_hi", {32'd0, hi}, 64'd0);
    chk("midrst_lo", {32'd0, lo}, 64'd0);
    chk("midrst_stall", {63'd0, stallreq}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("postrst_hi", {32'd0, hi}, 64'd0);
    chk("postrst_lo", {32'd0, lo}, 64'd0);
    do_op(3'd0, 32'd3, 32'd4, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
